// File: rtl/skel_pkg.sv
// Shared types and sizing helpers for the skeletonization frame buffer.
package skel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FEED,
        ST_WB,
        ST_CHECK,
        ST_DONE
    } skel_state_t;

    localparam int PASS_W = 5;

    function automatic int npix(input int n);
        return n * n;
    endfunction

endpackage

// File: rtl/pixel_ram.sv
// Frame store: one synchronous write port, two asynchronous read ports.
module pixel_ram #(
    parameter int NPIX = 64,
    parameter int AW   = 7,
    parameter int PW   = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [PW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [PW-1:0] rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [PW-1:0] rdata_b
);

    localparam int IW = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [AW:0] NPIX_X = (AW+1)'(NPIX);

    logic [PW-1:0] mem [NPIX];
    logic          w_ok;
    logic          a_ok;
    logic          b_ok;

    assign w_ok = ({1'b0, waddr} < NPIX_X);
    assign a_ok = ({1'b0, raddr_a} < NPIX_X);
    assign b_ok = ({1'b0, raddr_b} < NPIX_X);

    always_ff @(posedge clk) begin
        if (we && w_ok) begin
            mem[waddr[IW-1:0]] <= wdata;
        end
    end

    // Out-of-range reads return zero rather than aliasing into the frame.
    assign rdata_a = a_ok ? mem[raddr_a[IW-1:0]] : '0;
    assign rdata_b = b_ok ? mem[raddr_b[IW-1:0]] : '0;

endmodule

// File: rtl/skel_frame_buffer.sv
// Pass controller: loads the frame, feeds it to the convolution unit, captures
// the write-back, and repeats until the image is stable or the pass limit hits.
module skel_frame_buffer
    import skel_pkg::*;
#(
    parameter int N          = 8,
    parameter int bitSize    = 6,
    parameter int pixelWidth = 8,
    parameter int MAX_PASSES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  load_valid,
    input  logic [pixelWidth-1:0] load_data,
    input  logic                  wr_en,
    input  logic [bitSize:0]      wr_addr,
    input  logic [pixelWidth-1:0] wr_data,
    output logic                  mask_we,
    output logic [pixelWidth-1:0] mask_data,
    input  logic [bitSize:0]      rd_addr,
    output logic [pixelWidth-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [PASS_W-1:0]     pass_count
);

    localparam int NPIX = npix(N);
    localparam int AW   = bitSize + 1;
    localparam int FW   = $clog2(2 * NPIX);
    localparam int WW   = $clog2(4 * NPIX);

    localparam logic [AW-1:0]   LAST_PIX  = AW'(NPIX - 1);
    localparam logic [AW:0]     NPIX_X    = (AW+1)'(NPIX);
    localparam logic [FW-1:0]   FEED_LAST = FW'(2 * NPIX - 1);
    localparam logic [WW-1:0]   WB_LAST   = WW'(4 * NPIX - 1);
    localparam logic [PASS_W:0] MAX_P     = (PASS_W+1)'(MAX_PASSES);

    skel_state_t state;
    skel_state_t state_next;

    logic [AW-1:0]         load_idx;
    logic [FW-1:0]         feed_cnt;
    logic [WW-1:0]         wb_cnt;
    logic                  changed;
    logic                  wb_seen;
    logic                  error_q;
    logic [PASS_W-1:0]     pass_cnt;

    logic [FW:0]           feed_nxt;
    logic [AW-1:0]         feed_addr;
    logic [AW-1:0]         port_a_addr;
    logic [pixelWidth-1:0] port_a_data;
    logic                  ram_we;
    logic [AW-1:0]         ram_waddr;
    logic [pixelWidth-1:0] ram_wdata;

    logic wb_hit;
    logic wb_exit;
    logic wb_timeout;
    logic last_beat;
    logic feed_end;
    logic more_passes;

    // mask_data is registered, so the read address looks one feed cycle ahead.
    assign feed_nxt  = {1'b0, feed_cnt} + 1'b1;
    assign feed_addr = AW'(feed_nxt >> 1);

    assign wb_hit      = (state == ST_WB) && wr_en && ({1'b0, wr_addr} < NPIX_X);
    assign wb_exit     = (state == ST_WB) && wb_seen && !wr_en;
    assign wb_timeout  = (state == ST_WB) && !wb_exit && (wb_cnt == WB_LAST);
    assign last_beat   = (state == ST_LOAD) && load_valid && (load_idx == LAST_PIX);
    assign feed_end    = (state == ST_FEED) && (feed_cnt == FEED_LAST);
    assign more_passes = changed && (({1'b0, pass_cnt} + 1'b1) < MAX_P);

    assign port_a_addr = (state == ST_WB) ? wr_addr : feed_addr;

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = load_idx;
        ram_wdata = load_data;
        if (state == ST_LOAD) begin
            ram_we = load_valid;
        end else if (wb_hit) begin
            ram_we    = 1'b1;
            ram_waddr = wr_addr;
            ram_wdata = wr_data;
        end
    end

    pixel_ram #(
        .NPIX (NPIX),
        .AW   (AW),
        .PW   (pixelWidth)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .raddr_a (port_a_addr),
        .rdata_a (port_a_data),
        .raddr_b (rd_addr),
        .rdata_b (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: if (start) state_next = ST_LOAD;
            ST_LOAD:          if (last_beat) state_next = ST_FEED;
            ST_FEED:          if (feed_end) state_next = ST_WB;
            ST_WB: begin
                if (wb_exit) begin
                    state_next = ST_CHECK;
                end else if (wb_timeout) begin
                    state_next = ST_DONE;
                end
            end
            ST_CHECK:         state_next = more_passes ? ST_FEED : ST_DONE;
            default:          state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE) && (state != ST_DONE);
        done = (state == ST_DONE);
    end

    assign error      = error_q;
    assign pass_count = pass_cnt;

    // Entering FEED from either LOAD or CHECK forces a fresh 2*NPIX strobe;
    // WB and CHECK always separate passes with at least one idle cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_we   <= 1'b0;
            mask_data <= '0;
        end else begin
            mask_we   <= (state_next == ST_FEED);
            mask_data <= (state_next == ST_FEED) ? port_a_data : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_idx <= '0;
            feed_cnt <= '0;
            wb_cnt   <= '0;
            changed  <= 1'b0;
            wb_seen  <= 1'b0;
            error_q  <= 1'b0;
            pass_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        load_idx <= '0;
                        pass_cnt <= '0;
                        error_q  <= 1'b0;
                        changed  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (load_valid) load_idx <= load_idx + 1'b1;
                end
                ST_FEED: begin
                    feed_cnt <= feed_end ? '0 : feed_cnt + 1'b1;
                    wb_cnt   <= '0;
                    changed  <= 1'b0;
                    wb_seen  <= 1'b0;
                end
                ST_WB: begin
                    wb_cnt <= wb_cnt + 1'b1;
                    if (wr_en) wb_seen <= 1'b1;
                    if (wb_hit && (port_a_data != wr_data)) changed <= 1'b1;
                    if (wb_timeout) error_q <= 1'b1;
                end
                ST_CHECK: begin
                    pass_cnt <= pass_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_skel_frame_buffer.sv
// Scoreboard bench for skel_frame_buffer with a behavioural convolution-unit model.
module tb_skel_frame_buffer;

    localparam int N    = 8;
    localparam int NP   = N * N;
    localparam int PW   = 8;
    localparam int AW   = 7;
    localparam int MAXP = 16;

    typedef logic [NP*PW-1:0] frame_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          load_valid = 1'b0;
    logic [PW-1:0] load_data = '0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [PW-1:0] wr_data = '0;
    logic          mask_we;
    logic [PW-1:0] mask_data;
    logic [AW-1:0] rd_addr = '0;
    logic [PW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic          error;
    logic [4:0]    pass_count;

    int tests = 0;
    int fails = 0;

    frame_t exp_feed_q[$];
    frame_t exp_frame_q[$];
    int     exp_pass_q[$];
    bit     exp_err_q[$];

    int unit_mode = 0;
    int unit_pass = 0;
    int res_count = 0;

    always #5 clk = ~clk;

    skel_frame_buffer #(
        .N          (N),
        .bitSize    (AW - 1),
        .pixelWidth (PW),
        .MAX_PASSES (MAXP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .mask_we    (mask_we),
        .mask_data  (mask_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .pass_count (pass_count)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // What the external unit does to each pixel on a given pass.
    function automatic logic [PW-1:0] unit_f(input int mode, input int pass, input int addr,
                                             input logic [PW-1:0] v);
        case (mode)
            1:       return (pass == 1 && addr == 9) ? 8'd0 : v;
            2:       return (addr == 0) ? ~v : v;
            4:       return (pass < 4 && (addr % 7) == pass) ? (v ^ 8'h5A) : v;
            default: return v;
        endcase
    endfunction

    // Whole-frame reference: iterate passes until stable, the limit, or a timeout.
    task automatic refModel(input frame_t init, input int mode);
        frame_t f;
        frame_t nf;
        int     passes;
        bit     err;
        bit     more;
        f      = init;
        passes = 0;
        err    = 1'b0;
        more   = 1'b1;
        while (more) begin
            exp_feed_q.push_back(f);
            if (mode == 3) begin
                err  = 1'b1;
                more = 1'b0;
            end else begin
                for (int i = 0; i < NP; i++) nf[i*PW +: PW] = unit_f(mode, passes + 1, i, f[i*PW +: PW]);
                passes++;
                more = (nf != f) && (passes < MAXP);
                f    = nf;
            end
        end
        exp_frame_q.push_back(f);
        exp_pass_q.push_back(passes);
        exp_err_q.push_back(err);
    endtask

    task automatic writeBack(input frame_t cap);
        for (int i = 0; i < NP; i++) begin
            wr_en   = 1'b1;
            wr_addr = 7'(i);
            wr_data = unit_f(unit_mode, unit_pass, i, cap[i*PW +: PW]);
            @(negedge clk);
            if (unit_mode == 5 && i == 31) begin
                wr_addr = 7'd70;
                wr_data = 8'($urandom);
                @(negedge clk);
                wr_addr = 7'd31;
                wr_data = cap[31*PW +: PW];
                @(negedge clk);
            end
        end
        wr_en = 1'b0;
    endtask

    // Convolution-unit model: captures each strobe burst, then writes it back.
    initial begin
        frame_t cap;
        int     n;
        bit     aborted;
        forever begin
            @(negedge clk);
            if (rst_n && mask_we) begin
                n       = 0;
                cap     = '0;
                aborted = 1'b0;
                while (1) begin
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (!mask_we) break;
                    if (n < 2 * NP && (n % 2) == 0) cap[(n/2)*PW +: PW] = mask_data;
                    n++;
                    if (unit_mode == 5) begin
                        wr_en   = 1'($urandom_range(1));
                        wr_addr = 7'($urandom_range(NP - 1));
                        wr_data = 8'($urandom);
                    end
                    @(negedge clk);
                end
                wr_en = 1'b0;
                if (!aborted) begin
                    unit_pass++;
                    if (unit_mode != 3) writeBack(cap);
                end
            end
        end
    end

    // Feed monitor: each completed strobe burst is one expected pass image.
    initial begin
        logic [PW-1:0] burst[$];
        frame_t        expf;
        int            bad;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                burst.delete();
            end else if (mask_we) begin
                burst.push_back(mask_data);
            end else if (burst.size() > 0) begin
                if (exp_feed_q.size() == 0) begin
                    checkOutput("feed_unexpected", 32'(burst.size()), 0);
                end else begin
                    expf = exp_feed_q.pop_front();
                    bad  = 0;
                    foreach (burst[i]) begin
                        if (i >= 2 * NP || burst[i] !== expf[(i/2)*PW +: PW]) bad++;
                    end
                    checkOutput("feed_len", 32'(burst.size()), 32'(2 * NP));
                    checkOutput("feed_data", 32'(bad), 0);
                end
                burst.delete();
            end
        end
    end

    // Result monitor: on each rise of done, compare status and the whole frame.
    initial begin
        logic   prev = 1'b0;
        frame_t ef;
        int     ep;
        bit     ee;
        int     bad;
        forever begin
            @(negedge clk);
            if (rst_n && done && !prev) begin
                if (exp_pass_q.size() == 0) begin
                    checkOutput("done_unexpected", 32'(done), 0);
                end else begin
                    ef = exp_frame_q.pop_front();
                    ep = exp_pass_q.pop_front();
                    ee = exp_err_q.pop_front();
                    checkOutput("busy_in_done", 32'(busy), 0);
                    checkOutput("error", 32'(error), 32'(ee));
                    checkOutput("pass_count", 32'(pass_count), 32'(ep));
                    bad = 0;
                    for (int i = 0; i < NP; i++) begin
                        rd_addr = 7'(i);
                        #1;
                        if (rd_data !== ef[i*PW +: PW]) bad++;
                    end
                    checkOutput("frame_readback", 32'(bad), 0);
                    rd_addr = 7'd70;
                    #1;
                    checkOutput("rd_out_of_range", 32'(rd_data), 0);
                end
                res_count++;
            end
            prev = done;
        end
    end

    task automatic loadFrame(input frame_t init, input bit stalls);
        int beats;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        beats = 0;
        while (beats < NP) begin
            load_valid = stalls ? ($urandom_range(3) != 0) : 1'b1;
            load_data  = init[beats*PW +: PW];
            start      = (beats == 10);
            @(negedge clk);
            if (load_valid) beats++;
        end
        load_valid = 1'b0;
        start      = 1'b0;
    endtask

    task automatic applyStimulus(input int mode, input bit seq_data, output bit ok);
        frame_t init;
        int     target;
        for (int i = 0; i < NP; i++) init[i*PW +: PW] = seq_data ? 8'(i) : 8'($urandom);
        if (mode == 1) init[9*PW +: PW] = init[9*PW +: PW] | 8'h01;
        refModel(init, mode);
        unit_mode = mode;
        unit_pass = 0;
        target    = res_count + 1;
        loadFrame(init, 1'b1);
        ok = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            if (res_count >= target) begin
                ok = 1'b1;
                break;
            end
            load_valid = 1'($urandom_range(1));
            load_data  = 8'($urandom);
        end
        load_valid = 1'b0;
        if (!ok) checkOutput("run_timeout", 32'(res_count), 32'(target));
    endtask

    task automatic resetMidFeed();
        frame_t init;
        for (int i = 0; i < NP; i++) init[i*PW +: PW] = 8'(i);
        unit_mode = 0;
        unit_pass = 0;
        loadFrame(init, 1'b0);
        for (int c = 0; c < 10; c++) begin
            if (mask_we) break;
            @(negedge clk);
        end
        checkOutput("feed_started", 32'(mask_we), 1);
        repeat (40) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_mask_we", 32'(mask_we), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checkOutput("rst_error", 32'(error), 0);
        checkOutput("rst_pass_count", 32'(pass_count), 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        bit ok;
        int modes[7] = '{0, 1, 2, 3, -1, 5, 4};
        ok = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_mask_we", 32'(mask_we), 0);
        checkOutput("reset_mask_data", 32'(mask_data), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_done", 32'(done), 0);
        checkOutput("reset_pass_count", 32'(pass_count), 0);
        rst_n = 1'b1;
        foreach (modes[k]) begin
            if (!ok) break;
            if (modes[k] < 0) begin
                resetMidFeed();
            end else begin
                applyStimulus(modes[k], (k == 0), ok);
                if (ok && k == 0) begin
                    rd_addr = 7'd5;
                    #1;
                    checkOutput("rd_data_5", 32'(rd_data), 5);
                end
                if (ok && modes[k] == 1) begin
                    rd_addr = 7'd9;
                    #1;
                    checkOutput("rd_data_9", 32'(rd_data), 0);
                end
            end
        end
        repeat (5) @(negedge clk);
        checkOutput("feed_queue_drained", 32'(exp_feed_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
